// File: rtl/usb_rx_if.sv
// usb_rx_if: bundle between the receive front end and the bit decoder.
//   master: drives the sampled D+ level, bit strobe and eop and receives the decoded results.
//   slave : the bit decoder side.
// Signals:
//   d_plus, shift_enable, eop                        master -> slave
//   data_byte[BYTE_W], byte_valid, stuff_err,
//   align_err, sync_err, packet_done                 slave -> master
interface usb_rx_if #(
    parameter int unsigned BYTE_W = 8
);
    logic              d_plus;
    logic              shift_enable;
    logic              eop;
    logic [BYTE_W-1:0] data_byte;
    logic              byte_valid;
    logic              stuff_err;
    logic              align_err;
    logic              sync_err;
    logic              packet_done;

    modport master (
        output d_plus, shift_enable, eop,
        input  data_byte, byte_valid, stuff_err, align_err, sync_err, packet_done
    );

    modport slave (
        input  d_plus, shift_enable, eop,
        output data_byte, byte_valid, stuff_err, align_err, sync_err, packet_done
    );
endinterface

// File: rtl/usb_rx_bit_decoder.sv
// usb_rx_bit_decoder: USB full-speed receive bit decoder.
// NRZI-decodes D+ on each bit strobe, strips stuffed zeros, assembles LSB-first
// bytes and flags bit-stuff, alignment and (optional) sync errors; eop ends a packet.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rx (usb_rx_if.slave)
//     in : d_plus, shift_enable, eop
//     out: data_byte (held), byte_valid, stuff_err, align_err, sync_err, packet_done
//          (all registered; the flags are one-cycle pulses)
// Build option: define RX_SYNC_CHECK_EN to check the first byte of each packet
// against the sync pattern 8'h80 instead of delivering it.
module usb_rx_bit_decoder #(
    parameter int unsigned STUFF_RUN = 6,
    parameter int unsigned BYTE_W    = 8
) (
    input  logic    clk,
    input  logic    rst,
    usb_rx_if.slave rx
);
    localparam int unsigned ONES_W = $clog2(STUFF_RUN + 1);
    localparam int unsigned BITS_W = $clog2(BYTE_W);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        ERR,
        EOP
    } state_e;

    state_e              state_q, state_d;
    logic                prev_q, prev_d;
    logic [BYTE_W-1:0]   sr_q, sr_d;
    logic [BITS_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                bv_q, bv_d;
    logic                stuff_q, stuff_d;
    logic                align_q, align_d;
    logic                done_q, done_d;
    logic                dec_bit_c;
    logic                shift_c;
    logic [BYTE_W-1:0]   shifted_c;
`ifdef RX_SYNC_CHECK_EN
    localparam logic [BYTE_W-1:0] SYNC_BYTE = BYTE_W'(8'h80);
    logic                first_q, first_d;
    logic                sync_q, sync_d;
`endif

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        data_d    = data_q;
        bv_d      = 1'b0;
        stuff_d   = 1'b0;
        align_d   = 1'b0;
        done_d    = 1'b0;
`ifdef RX_SYNC_CHECK_EN
        first_d   = first_q;
        sync_d    = 1'b0;
`endif
        // eop masks the strobe: no decode and the reference level is kept
        shift_c   = rx.shift_enable & ~rx.eop;
        dec_bit_c = ~(rx.d_plus ^ prev_q);
        shifted_c = {dec_bit_c, sr_q[BYTE_W-1:1]};
        if (shift_c) begin
            prev_d = rx.d_plus;
        end

        unique case (state_q)
            IDLE: begin
                // first J->K transition starts the sync byte
                if (shift_c && !dec_bit_c) begin
                    state_d   = RECV;
                    sr_d      = shifted_c;
                    bit_cnt_d = BITS_W'(1);
                    ones_d    = '0;
`ifdef RX_SYNC_CHECK_EN
                    first_d   = 1'b1;
`endif
                end
            end
            RECV: begin
                if (rx.eop) begin
                    state_d   = EOP;
                    done_d    = 1'b1;
                    align_d   = (bit_cnt_q != '0);
                    bit_cnt_d = '0;
                    ones_d    = '0;
                end else if (shift_c) begin
                    if (ones_q == ONES_W'(STUFF_RUN)) begin
                        if (dec_bit_c) begin
                            stuff_d = 1'b1;
                            state_d = ERR;
                        end else begin
                            ones_d = '0;
                        end
                    end else begin
                        sr_d   = shifted_c;
                        ones_d = dec_bit_c ? ONES_W'(ones_q + ONES_W'(1)) : '0;
                        if (bit_cnt_q == BITS_W'(BYTE_W - 1)) begin
                            bit_cnt_d = '0;
`ifdef RX_SYNC_CHECK_EN
                            first_d = 1'b0;
                            if (first_q) begin
                                if (shifted_c != SYNC_BYTE) begin
                                    sync_d  = 1'b1;
                                    state_d = ERR;
                                end
                            end else begin
                                data_d = shifted_c;
                                bv_d   = 1'b1;
                            end
`else
                            data_d = shifted_c;
                            bv_d   = 1'b1;
`endif
                        end else begin
                            bit_cnt_d = BITS_W'(bit_cnt_q + BITS_W'(1));
                        end
                    end
                end
            end
            ERR: begin
                if (rx.eop) begin
                    state_d   = EOP;
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                    ones_d    = '0;
                end
            end
            EOP: begin
                bit_cnt_d = '0;
                ones_d    = '0;
                if (!rx.eop) begin
                    state_d = IDLE;
                    prev_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_q    <= 1'b1;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            ones_q    <= '0;
            data_q    <= '0;
            bv_q      <= 1'b0;
            stuff_q   <= 1'b0;
            align_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef RX_SYNC_CHECK_EN
            first_q   <= 1'b0;
            sync_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            data_q    <= data_d;
            bv_q      <= bv_d;
            stuff_q   <= stuff_d;
            align_q   <= align_d;
            done_q    <= done_d;
`ifdef RX_SYNC_CHECK_EN
            first_q   <= first_d;
            sync_q    <= sync_d;
`endif
        end
    end

    assign rx.data_byte   = data_q;
    assign rx.byte_valid  = bv_q;
    assign rx.stuff_err   = stuff_q;
    assign rx.align_err   = align_q;
    assign rx.packet_done = done_q;
`ifdef RX_SYNC_CHECK_EN
    assign rx.sync_err    = sync_q;
`else
    assign rx.sync_err    = 1'b0;
`endif

endmodule
